// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-cycle data memory: CPU load/store path vs DMA/loader port.
// Build option: DMARB_ROUND_ROBIN_EN selects round-robin contention; default is fixed CPU priority with a DMA starvation guard.
module dmem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_LOCK     = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int unsigned LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA} state_t;

    state_t        state, state_next;
    logic [LW-1:0] lock_cnt;
    logic          cpu_beat, dma_beat, lock_hold, pick_dma;

`ifdef DMARB_ROUND_ROBIN_EN
    typedef enum logic {GRANT_CPU, GRANT_DMA} grant_t;
    grant_t last_grant, recent_grant;
`else
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
`endif

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    // Owner register: the only source of grant.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Memory steering, ready generation and next-owner selection.
    always_comb begin
        state_next = IDLE;
        cpu_beat   = 1'b0;
        dma_beat   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        pick_dma   = 1'b0;
`ifdef DMARB_ROUND_ROBIN_EN
        recent_grant = last_grant;
`endif

        case (state)
            OWN_CPU: if (cpu_req) begin
                cpu_beat  = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_DMA: if (dma_req) begin
                dma_beat  = 1'b1;
                mem_we    = dma_we;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            default: ;
        endcase

        cpu_ready = cpu_beat;
        dma_ready = dma_beat;
        cpu_stall = cpu_req & ~cpu_beat;

        lock_hold = (state == OWN_DMA) && dma_lock && (lock_cnt < LW'(MAX_LOCK - 1));

`ifdef DMARB_ROUND_ROBIN_EN
        // The beat finishing at this edge counts as the most recent grant.
        if (cpu_beat)      recent_grant = GRANT_CPU;
        else if (dma_beat) recent_grant = GRANT_DMA;
        pick_dma = (recent_grant == GRANT_CPU);
`else
        // A starved DMA wins exactly one decision; its own beat closes the window.
        pick_dma = (starve_cnt == SW'(STARVE_LIMIT)) && !dma_beat;
`endif

        if (cpu_req && dma_req) begin
            if (lock_hold)     state_next = OWN_DMA;
            else if (pick_dma) state_next = OWN_DMA;
            else               state_next = OWN_CPU;
        end else if (cpu_req) begin
            state_next = OWN_CPU;
        end else if (dma_req) begin
            state_next = OWN_DMA;
        end
    end

    // Burst-lock counter; saturates so a long uncontended burst cannot wrap back under the bound.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (state == OWN_DMA && state_next != OWN_DMA) begin
            lock_cnt <= '0;
        end else if (dma_beat && lock_cnt != LW'(MAX_LOCK)) begin
            lock_cnt <= lock_cnt + LW'(1);
        end
    end

`ifdef DMARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)         last_grant <= GRANT_DMA;
        else if (cpu_beat) last_grant <= GRANT_CPU;
        else if (dma_beat) last_grant <= GRANT_DMA;
    end
`else
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)                                        starve_cnt <= '0;
        else if (dma_beat)                                starve_cnt <= '0;
        else if (dma_req && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_dmem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MAX_LOCK = 8;
    localparam int unsigned STARVE_LIMIT = 4;

    logic          CLK = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_ready, cpu_stall, dma_ready, mem_we;

    logic [DW-1:0] tb_mem  [256];
    logic [DW-1:0] ref_mem [256];

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: owner 0=none 1=CPU 2=DMA.
    int m_owner, m_lock, m_starve, m_last;

    always #5 CLK = ~CLK;

    assign mem_rdata = tb_mem[mem_addr[7:0]];

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function void model_reset();
        m_owner = 0; m_lock = 0; m_starve = 0; m_last = 2;
    endfunction

    // Apply the arbitration rules for one clock edge using the current inputs.
    function void model_edge();
        bit cb, db;
        int nxt, recent;
        cb = (m_owner == 1) && cpu_req;
        db = (m_owner == 2) && dma_req;
        if (cb && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
        if (db && dma_we) ref_mem[dma_addr[7:0]] = dma_wdata;
        recent = cb ? 1 : (db ? 2 : m_last);
        if (cpu_req && dma_req) begin
            if (m_owner == 2 && dma_lock && m_lock < MAX_LOCK - 1) nxt = 2;
`ifdef DMARB_ROUND_ROBIN_EN
            else nxt = (recent == 1) ? 2 : 1;
`else
            else nxt = (m_starve == STARVE_LIMIT && !db) ? 2 : 1;
`endif
        end else if (cpu_req) nxt = 1;
        else if (dma_req) nxt = 2;
        else nxt = 0;
        if (m_owner == 2 && nxt != 2) m_lock = 0;
        else if (db) m_lock = m_lock + 1;
`ifndef DMARB_ROUND_ROBIN_EN
        if (db) m_starve = 0;
        else if (dma_req && m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
`endif
        m_last = recent;
        m_owner = nxt;
    endfunction

    // Commit the memory write the DUT presents, advance the model, move past the edge.
    task automatic adv();
        if (mem_we) tb_mem[mem_addr[7:0]] = mem_wdata;
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        #2;
        check_cnt++; if ({cpu_ready, dma_ready, cpu_stall, mem_we} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {cpu_ready, dma_ready, cpu_stall, mem_we}); else pass_cnt++;
        check_cnt++; if (mem_addr !== '0) $display("FAIL reset_addr: got %h expected 0", mem_addr); else pass_cnt++;
        check_cnt++; if (mem_wdata !== '0) $display("FAIL reset_wdata: got %h expected 0", mem_wdata); else pass_cnt++;
        @(posedge CLK);
        cpu_req = 1; dma_req = 1;
        #2;
        check_cnt++; if ({cpu_ready, dma_ready} !== 2'b00)
            $display("FAIL reset_held_ready: got %b expected 00", {cpu_ready, dma_ready}); else pass_cnt++;
        idle_inputs();
        @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_cpu_write();
        apply_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        @(negedge CLK);
        check_cnt++; if ({cpu_ready, cpu_stall, mem_we} !== 3'b010)
            $display("FAIL wr_first_cycle: got %b expected 010", {cpu_ready, cpu_stall, mem_we}); else pass_cnt++;
        adv();
        @(negedge CLK);
        check_cnt++; if ({cpu_ready, cpu_stall, mem_we} !== 3'b101)
            $display("FAIL wr_beat_flags: got %b expected 101", {cpu_ready, cpu_stall, mem_we}); else pass_cnt++;
        check_cnt++; if (mem_addr !== 32'h10) $display("FAIL wr_beat_addr: got %h expected 10", mem_addr); else pass_cnt++;
        check_cnt++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL wr_beat_data: got %h expected deadbeef", mem_wdata); else pass_cnt++;
        adv();
        cpu_req = 0; cpu_we = 0;
        @(negedge CLK);
        check_cnt++; if ({cpu_ready, mem_we} !== 2'b00)
            $display("FAIL wr_released: got %b expected 00", {cpu_ready, mem_we}); else pass_cnt++;
        adv();
        cpu_req = 1;
        @(negedge CLK);
        adv();
        @(negedge CLK);
        check_cnt++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEADBEEF)
            $display("FAIL rd_back: got ready=%b data=%h expected ready=1 data=deadbeef", cpu_ready, cpu_rdata); else pass_cnt++;
        adv();
        idle_inputs();
        @(negedge CLK);
        adv();
    endtask

`ifdef DMARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        apply_reset();
        cpu_req = 1; cpu_addr = 32'h4; dma_req = 1; dma_addr = 32'h8;
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            check_cnt++;
            if ({cpu_ready, dma_ready} !== ((k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01)))
                $display("FAIL rr_cycle%0d: got %b expected %b", k, {cpu_ready, dma_ready},
                         (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01));
            else pass_cnt++;
            adv();
        end
        idle_inputs();
        @(negedge CLK);
        adv();
    endtask
`else
    task automatic test_starvation();
        logic [1:0] exp;
        apply_reset();
        cpu_req = 1; cpu_addr = 32'h4; dma_req = 1; dma_addr = 32'h8;
        for (int k = 0; k < 8; k++) begin
            exp = (k == 0) ? 2'b00 : ((k == 5) ? 2'b01 : 2'b10);
            @(negedge CLK);
            check_cnt++;
            if ({cpu_ready, dma_ready} !== exp)
                $display("FAIL starve_cycle%0d: got %b expected %b", k, {cpu_ready, dma_ready}, exp);
            else pass_cnt++;
            adv();
        end
        idle_inputs();
        @(negedge CLK);
        adv();
    endtask
`endif

    task automatic test_lock();
        int dma_beats;
        apply_reset();
        dma_beats = 0;
        dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h55AA;
        for (int k = 0; k < 10; k++) begin
            if (k >= 1) begin cpu_req = 1; cpu_addr = 32'h44; end
            @(negedge CLK);
            if (dma_ready) dma_beats++;
            if (k == 9) begin
                check_cnt++; if ({cpu_ready, dma_ready} !== 2'b10)
                    $display("FAIL lock_handover: got %b expected 10", {cpu_ready, dma_ready}); else pass_cnt++;
            end
            adv();
        end
        check_cnt++; if (dma_beats != MAX_LOCK)
            $display("FAIL lock_beats: got %0d expected %0d", dma_beats, MAX_LOCK); else pass_cnt++;
        idle_inputs();
        @(negedge CLK);
        adv();
    endtask

    task automatic test_reset_mid_beat();
        logic [DW-1:0] old;
        apply_reset();
        old = tb_mem[8'h20];
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = ~old;
        @(negedge CLK);
        adv();
        @(negedge CLK);
        check_cnt++; if ({dma_ready, mem_we} !== 2'b11)
            $display("FAIL rstbeat_active: got %b expected 11", {dma_ready, mem_we}); else pass_cnt++;
        #1;
        reset = 1'b1;
        #1;
        check_cnt++; if ({dma_ready, mem_we} !== 2'b00 || mem_addr !== '0 || mem_wdata !== '0)
            $display("FAIL rstbeat_drop: got ready=%b we=%b addr=%h wdata=%h expected all 0", dma_ready, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        idle_inputs();
        model_reset();
        adv();
        reset = 1'b0;
        check_cnt++; if (tb_mem[8'h20] !== old)
            $display("FAIL rstbeat_mem: got %h expected %h", tb_mem[8'h20], old); else pass_cnt++;
        cpu_req = 1; cpu_addr = 32'h20;
        @(negedge CLK);
        check_cnt++; if (cpu_ready !== 1'b0) $display("FAIL rstbeat_idle: got %b expected 0", cpu_ready); else pass_cnt++;
        adv();
        @(negedge CLK);
        check_cnt++; if (cpu_ready !== 1'b1 || cpu_rdata !== old)
            $display("FAIL rstbeat_read: got ready=%b data=%h expected ready=1 data=%h", cpu_ready, cpu_rdata, old); else pass_cnt++;
        adv();
        idle_inputs();
        @(negedge CLK);
        adv();
    endtask

    task automatic test_dma_drop();
        apply_reset();
        dma_req = 1; dma_addr = 32'h30;
        @(negedge CLK);
        adv();
        @(negedge CLK);
        check_cnt++; if (dma_ready !== 1'b1) $display("FAIL drop_beat: got %b expected 1", dma_ready); else pass_cnt++;
        adv();
        dma_req = 0; dma_we = 1;
        @(negedge CLK);
        check_cnt++; if ({dma_ready, mem_we} !== 2'b00 || mem_addr !== '0)
            $display("FAIL drop_quiet: got ready=%b we=%b addr=%h expected 0 0 0", dma_ready, mem_we, mem_addr); else pass_cnt++;
        adv();
        dma_req = 1; dma_we = 0;
        @(negedge CLK);
        check_cnt++; if (dma_ready !== 1'b0) $display("FAIL drop_idle: got %b expected 0", dma_ready); else pass_cnt++;
        adv();
        @(negedge CLK);
        check_cnt++; if (dma_ready !== 1'b1) $display("FAIL drop_regrant: got %b expected 1", dma_ready); else pass_cnt++;
        adv();
        idle_inputs();
        @(negedge CLK);
        adv();
    endtask

    task automatic test_random();
        bit            c_done, d_done, e_cr, e_dr;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        apply_reset();
        c_done = 1; d_done = 1;
        for (int i = 0; i < 600; i++) begin
            if (!cpu_req || c_done) begin
                cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 255)); cpu_wdata = $urandom;
            end
            if (!dma_req || d_done) begin
                dma_req = ($urandom_range(0, 3) != 0); dma_we = 1'($urandom_range(0, 1));
                dma_lock = ($urandom_range(0, 3) != 0);
                dma_addr = AW'($urandom_range(0, 255)); dma_wdata = $urandom;
            end
            @(negedge CLK);
            e_cr = (m_owner == 1) && cpu_req;
            e_dr = (m_owner == 2) && dma_req;
            e_we = e_cr ? cpu_we : (e_dr ? dma_we : 1'b0);
            e_addr = e_cr ? cpu_addr : (e_dr ? dma_addr : '0);
            e_wd = e_cr ? cpu_wdata : (e_dr ? dma_wdata : '0);
            check_cnt++;
            if ({cpu_ready, dma_ready, cpu_stall, mem_we, mem_addr, mem_wdata} !==
                {e_cr, e_dr, (cpu_req && !e_cr), e_we, e_addr, e_wd})
                $display("FAIL rand_cycle%0d: got rdy=%b%b stall=%b we=%b addr=%h wd=%h expected rdy=%b%b stall=%b we=%b addr=%h wd=%h",
                         i, cpu_ready, dma_ready, cpu_stall, mem_we, mem_addr, mem_wdata,
                         e_cr, e_dr, (cpu_req && !e_cr), e_we, e_addr, e_wd);
            else pass_cnt++;
            if ((e_cr || e_dr) && !e_we) begin
                e_rd = ref_mem[e_addr[7:0]];
                check_cnt++;
                if (cpu_rdata !== e_rd || dma_rdata !== e_rd)
                    $display("FAIL rand_rdata%0d: got cpu=%h dma=%h expected %h", i, cpu_rdata, dma_rdata, e_rd);
                else pass_cnt++;
            end
            c_done = e_cr; d_done = e_dr;
            adv();
        end
        idle_inputs();
        @(negedge CLK);
        adv();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000;
            ref_mem[i] = (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000;
        end
        test_reset();
        test_cpu_write();
`ifdef DMARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_starvation();
`endif
        test_lock();
        test_reset_mid_beat();
        test_dma_drop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
